clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8: width of divide ratio.
REQ-003 SHALL have parameter DIV_RST, default 2: ratio loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1: single reference clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port en  input  NUM_CH: per-channel run request.
REQ-007 SHALL have port cfg_valid  input  1: ratio-update request.
REQ-008 SHALL have port cfg_ch  input  max(1,$clog2(NUM_CH)): target channel of update.
REQ-009 SHALL have port cfg_div  input  DIV_W: new divide ratio D.
REQ-010 SHALL have port cfg_ready  output  1: update accepted when cfg_valid and cfg_ready both high at a clk edge.
REQ-011 SHALL have port clk_out  output  NUM_CH: registered divided clocks.
REQ-012 SHALL have port busy  output  NUM_CH: channel not in OFF state.

Function
REQ-013 Each channel SHALL implement FSM OFF, RUN, DRAIN with a cnt register counting 0..D-1.
REQ-014 OFF->RUN SHALL occur on the edge where en[ch]=1 is sampled; at that edge cnt<=0 and clk_out[ch]<=1.
REQ-015 In RUN, clk_out[ch] SHALL be high for cnt < ceil(D/2) and low otherwise, giving period D cycles with high phase ceil(D/2) and low phase floor(D/2).
REQ-016 RUN->DRAIN SHALL occur when en[ch]=0 is sampled mid-period; the period SHALL complete unchanged.
REQ-017 DRAIN->OFF SHALL occur at the period boundary (cnt==D-1); clk_out[ch] SHALL stay low in OFF, so no truncated high pulse is ever produced.
REQ-018 DRAIN->RUN SHALL occur at the period boundary if en[ch]=1 is sampled again there; the period restarts seamlessly.
REQ-019 cfg_div values 0 and 1 SHALL be clamped to 2.
REQ-020 An accepted update SHALL write a per-channel shadow register and set pending[ch].
REQ-021 A pending ratio SHALL be applied at the next period boundary in RUN/DRAIN, or on the next edge if the channel is OFF; pending[ch] clears on application.
REQ-022 cfg_ready SHALL equal ~pending[cfg_ch] combinationally; only one update per channel may be outstanding.
REQ-023 busy[ch] SHALL be 1 in RUN and DRAIN, 0 in OFF.
REQ-024 Channels SHALL be fully independent; simultaneous en changes and an update on any channel in the same cycle SHALL each behave as if alone.

Reset
REQ-025 While rst_n=0: all channels OFF, cnt=0, ratio=DIV_RST, pending=0, clk_out=0, busy=0, cfg_ready=1.
REQ-026 Reset assertion mid-period SHALL force clk_out low immediately (asynchronous), discarding pending updates.
REQ-027 After reset release, a channel with en already high SHALL start on the first clk edge.

Configuration
REQ-028 Macro CLK_DIV_BANK_TICK_EN SHALL, when defined, add output tick  NUM_CH: one-cycle registered pulse coincident with every 0->1 transition of clk_out[ch].
REQ-029 Without CLK_DIV_BANK_TICK_EN the tick port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package clk_div_pkg SHALL hold typedef ch_state_e (OFF, RUN, DRAIN) and constant DIV_MIN=2.
REQ-031 Per-channel FSM, counter, shadow register and pending flag SHALL live in sub-module clk_div_channel, generated NUM_CH times; top holds cfg decode and cfg_ready mux.

Verification
REQ-032 Reset, en[0]=1, default D=2 -> clk_out[0] toggles 1,0,1,0 each cycle from first edge; busy[0]=1.
REQ-033 Update ch1 D=5 while OFF, then en[1]=1 -> clk_out[1] pattern 1,1,1,0,0 repeating.
REQ-034 ch2 running D=4, update D=6 at cnt=1 -> current period stays 4 cycles, next period 6 (3 high, 3 low); cfg_ready low for cfg_ch=2 until boundary.
REQ-035 ch0 D=8, drop en at cnt=2 -> high phase finishes (4), low phase 4, then OFF, busy falls at boundary; no short pulse.
REQ-036 cfg_div=1 on ch3 -> behaves as D=2; rst_n low at cnt=3 of D=8 -> clk_out 0 immediately, ratio back to DIV_RST.
REQ-037 With CLK_DIV_BANK_TICK_EN, D=3 -> tick high once every 3 cycles, aligned with clk_out rising.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock bank.
package clk_div_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ch_state_e;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: OFF/RUN/DRAIN FSM, period counter, shadow ratio.
// Optional tick output when CLK_DIV_BANK_TICK_EN is defined.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             pending,
    output logic             clk_out,
`ifdef CLK_DIV_BANK_TICK_EN
    output logic             tick,
`endif
    output logic             busy
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic [DIV_W-1:0] next_ratio, cnt_inc, high_len;
    logic             boundary;

    always_comb begin
        next_ratio = pending_q ? shadow_q : ratio_q;
        boundary   = (cnt_q == ratio_q - DIV_W'(1));
        cnt_inc    = cnt_q + DIV_W'(1);
        // ceil(D/2) without needing an extra bit
        high_len   = {1'b0, ratio_q[DIV_W-1:1]} + DIV_W'(ratio_q[0]);

        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_d     = clk_q;

        unique case (state_q)
            OFF: begin
                ratio_d   = next_ratio;
                pending_d = 1'b0;
                cnt_d     = '0;
                clk_d     = en;
                if (en) state_d = RUN;
            end
            RUN, DRAIN: begin
                if (boundary) begin
                    ratio_d   = next_ratio;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    clk_d     = en;
                    state_d   = en ? RUN : OFF;
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < high_len);
                    if (state_q == RUN && !en) state_d = DRAIN;
                end
            end
            default: begin
                state_d = OFF;
                clk_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Writes only arrive while nothing is pending, so this never races an apply.
        if (cfg_we) begin
            shadow_d  = cfg_div;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            ratio_q   <= DIV_W'(DIV_RST);
            shadow_q  <= DIV_W'(DIV_RST);
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
        end
    end

`ifdef CLK_DIV_BANK_TICK_EN
    logic tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= clk_d & ~clk_q;
    end

    assign tick = tick_q;
`endif

    assign pending = pending_q;
    assign clk_out = clk_q;
    assign busy    = (state_q != OFF);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers with a shared ratio-update port.
// Define CLK_DIV_BANK_TICK_EN to add the per-channel rising-edge tick output.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 2,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_out,
`ifdef CLK_DIV_BANK_TICK_EN
    output logic [NUM_CH-1:0] tick,
`endif
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_we;
    logic [DIV_W-1:0]  div_clamped;

    always_comb begin
        div_clamped = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
        // Out-of-range channel numbers are accepted and dropped.
        cfg_ready = 1'b1;
        if (32'(cfg_ch) < NUM_CH) cfg_ready = ~pending[cfg_ch];
        cfg_we = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cfg_we[i] = cfg_valid && cfg_ready && (32'(cfg_ch) == i);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .cfg_we  (cfg_we[i]),
            .cfg_div (div_clamped),
            .pending (pending[i]),
            .clk_out (clk_out[i]),
`ifdef CLK_DIV_BANK_TICK_EN
            .tick    (tick[i]),
`endif
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (default parameters).
module tb_clk_div_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] en;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic [3:0] clk_out;
    logic [3:0] busy;
`ifdef CLK_DIV_BANK_TICK_EN
    logic [3:0] tick;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
`ifdef CLK_DIV_BANK_TICK_EN
        .tick      (tick),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic       cfg_valid;
        logic [1:0] cfg_ch;
        logic [7:0] cfg_div;
        logic [3:0] exp_clk;
        logic [3:0] exp_busy;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic [3:0] e, input logic v, input logic [1:0] ch,
                                input logic [7:0] d, input logic [3:0] ec,
                                input logic [3:0] eb, input logic er);
        vec_t r;
        r.en = e; r.cfg_valid = v; r.cfg_ch = ch; r.cfg_div = d;
        r.exp_clk = ec; r.exp_busy = eb; r.exp_ready = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Program a ratio into an idle channel and let it apply.
    task automatic cfg_idle(input logic [1:0] ch, input logic [7:0] d);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = d;
        tick_edge();
        cfg_valid = 1'b0;
        tick_edge();
    endtask

    initial begin
        // ch0 D=2 and ch1 D=5 side by side, both draining; then ch3 with a clamped ratio of 1
        vecs[0]  = mk(4'b0001, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001, 1'b1);
        vecs[1]  = mk(4'b0001, 1'b1, 2'd1, 8'd5, 4'b0000, 4'b0001, 1'b0);
        vecs[2]  = mk(4'b0001, 1'b0, 2'd1, 8'd0, 4'b0001, 4'b0001, 1'b1);
        vecs[3]  = mk(4'b0011, 1'b0, 2'd1, 8'd0, 4'b0010, 4'b0011, 1'b1);
        vecs[4]  = mk(4'b0011, 1'b0, 2'd1, 8'd0, 4'b0011, 4'b0011, 1'b1);
        vecs[5]  = mk(4'b0011, 1'b0, 2'd1, 8'd0, 4'b0010, 4'b0011, 1'b1);
        vecs[6]  = mk(4'b0011, 1'b0, 2'd1, 8'd0, 4'b0001, 4'b0011, 1'b1);
        vecs[7]  = mk(4'b0011, 1'b0, 2'd1, 8'd0, 4'b0000, 4'b0011, 1'b1);
        vecs[8]  = mk(4'b0011, 1'b0, 2'd1, 8'd0, 4'b0011, 4'b0011, 1'b1);
        vecs[9]  = mk(4'b0000, 1'b0, 2'd1, 8'd0, 4'b0010, 4'b0011, 1'b1);
        vecs[10] = mk(4'b0000, 1'b0, 2'd1, 8'd0, 4'b0010, 4'b0010, 1'b1);
        vecs[11] = mk(4'b0000, 1'b0, 2'd1, 8'd0, 4'b0000, 4'b0010, 1'b1);
        vecs[12] = mk(4'b0000, 1'b0, 2'd1, 8'd0, 4'b0000, 4'b0010, 1'b1);
        vecs[13] = mk(4'b0000, 1'b0, 2'd1, 8'd0, 4'b0000, 4'b0000, 1'b1);
        vecs[14] = mk(4'b0000, 1'b1, 2'd3, 8'd1, 4'b0000, 4'b0000, 1'b0);
        vecs[15] = mk(4'b0000, 1'b0, 2'd3, 8'd0, 4'b0000, 4'b0000, 1'b1);
        vecs[16] = mk(4'b1000, 1'b0, 2'd3, 8'd0, 4'b1000, 4'b1000, 1'b1);
        vecs[17] = mk(4'b1000, 1'b0, 2'd3, 8'd0, 4'b0000, 4'b1000, 1'b1);
        vecs[18] = mk(4'b1000, 1'b0, 2'd3, 8'd0, 4'b1000, 4'b1000, 1'b1);
        vecs[19] = mk(4'b0000, 1'b0, 2'd3, 8'd0, 4'b0000, 4'b1000, 1'b1);
        vecs[20] = mk(4'b0000, 1'b0, 2'd3, 8'd0, 4'b0000, 4'b0000, 1'b1);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            en = vecs[i].en; cfg_valid = vecs[i].cfg_valid;
            cfg_ch = vecs[i].cfg_ch; cfg_div = vecs[i].cfg_div;
            tick_edge();
            check($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(vecs[i].exp_clk));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(vecs[i].exp_ready));
        end

        // ch2 D=4, update to 6 accepted at cnt=1: 4-cycle period then 3 high / 3 low
        begin
            logic ec [11];
            logic er [11];
            ec = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            do_reset();
            cfg_idle(2'd2, 8'd4);
            en = 4'b0100; cfg_ch = 2'd2; cfg_div = 8'd6;
            for (int k = 0; k < 11; k++) begin
                cfg_valid = (k == 2);
                tick_edge();
                check($sformatf("upd_clk%0d", k), 32'(clk_out[2]), 32'(ec[k]));
                check($sformatf("upd_ready%0d", k), 32'(cfg_ready), 32'(er[k]));
            end
            cfg_valid = 1'b0;
            en = '0;
        end

        // ch0 D=8, en dropped at cnt=2: full period completes, then OFF
        begin
            logic ec [10];
            logic eb [10];
            ec = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            do_reset();
            cfg_idle(2'd0, 8'd8);
            for (int k = 0; k < 10; k++) begin
                en = (k < 3) ? 4'b0001 : 4'b0000;
                tick_edge();
                check($sformatf("drain_clk%0d", k), 32'(clk_out[0]), 32'(ec[k]));
                check($sformatf("drain_busy%0d", k), 32'(busy[0]), 32'(eb[k]));
            end
        end

        // Reset at cnt=3 of D=8 with an update pending: output drops at once, ratio reverts
        begin
            logic ec [4];
            ec = '{1'b1, 1'b0, 1'b1, 1'b0};
            en = 4'b0001; cfg_ch = 2'd0; cfg_div = 8'd5;
            for (int k = 0; k < 4; k++) begin
                cfg_valid = (k == 1);
                tick_edge();
            end
            cfg_valid = 1'b0;
            check("pre_rst_clk", 32'(clk_out[0]), 32'h1);
            check("pre_rst_ready", 32'(cfg_ready), 32'h0);
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_clk", 32'(clk_out), 32'h0);
            check("async_rst_busy", 32'(busy), 32'h0);
            check("async_rst_ready", 32'(cfg_ready), 32'h1);
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                tick_edge();
                check($sformatf("post_rst_clk%0d", k), 32'(clk_out[0]), 32'(ec[k]));
            end
            en = '0;
        end

`ifdef CLK_DIV_BANK_TICK_EN
        // ch1 D=3: tick marks each rising edge of clk_out
        begin
            logic ec [7];
            logic et [7];
            ec = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            et = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            do_reset();
            cfg_idle(2'd1, 8'd3);
            en = 4'b0010;
            for (int k = 0; k < 7; k++) begin
                tick_edge();
                check($sformatf("tick_clk%0d", k), 32'(clk_out[1]), 32'(ec[k]));
                check($sformatf("tick%0d", k), 32'(tick[1]), 32'(et[k]));
            end
            en = '0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
